// File: rtl/addr_dec_target.sv
// rtl/addr_dec_target.sv - decoder target: 16x8 register file with programmable wait states and one-cycle ack
module addr_dec_target #(
  parameter int SLAVE_ID    = 0,
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] sel_en_in,
  input  logic       wr_rd_s_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] wr_data_in,
  output logic [7:0] rd_data_out,
  output logic       ack_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [7:0] ID_VALUE  = 8'hA0 | 8'(SLAVE_ID);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic       cap_wr;
  logic [7:0] cap_addr;
  logic [7:0] cap_data;
  logic [7:0] regs [0:14];
  logic       sel;
  logic       in_range;
  logic       is_id;

  assign sel      = sel_en_in[SLAVE_ID];
  assign in_range = (cap_addr[7:4] == 4'h0);
  assign is_id    = (cap_addr[3:0] == 4'hF);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'h0;
      cap_wr   <= 1'b0;
      cap_addr <= 8'h00;
      cap_data <= 8'h00;
      for (int i = 0; i < 15; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      state <= state_next;
      if (state == ST_IDLE && sel) begin
        cap_wr   <= wr_rd_s_in;
        cap_addr <= addr_in;
        cap_data <= wr_data_in;
        wait_cnt <= 4'h0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      // Writes land only at the end of the ack cycle, so an abort or reset never commits.
      if (state == ST_ACK && cap_wr && in_range && !is_id) begin
        regs[cap_addr[3:0]] <= cap_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (sel) begin
          state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!sel) begin
          state_next = ST_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK: state_next = ST_RELEASE;
      ST_RELEASE: begin
        if (!sel) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_out     = 1'b0;
    rd_data_out = 8'h00;
    if (state == ST_ACK) begin
      ack_out = 1'b1;
      if (!cap_wr) begin
        if (!in_range) begin
          rd_data_out = 8'hFF;
        end else if (is_id) begin
          rd_data_out = ID_VALUE;
        end else begin
          rd_data_out = regs[cap_addr[3:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_addr_dec_target.sv
// tb/tb_addr_dec_target.sv - directed bench for addr_dec_target with SLAVE_ID=2, WAIT_CYCLES=2
module tb_addr_dec_target;

  logic       clock;
  logic       reset;
  logic [4:0] sel_en_in;
  logic       wr_rd_s_in;
  logic [7:0] addr_in;
  logic [7:0] wr_data_in;
  logic [7:0] rd_data_out;
  logic       ack_out;

  int n_checks = 0;
  int n_fail   = 0;

  addr_dec_target #(.SLAVE_ID(2), .WAIT_CYCLES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .sel_en_in  (sel_en_in),
    .wr_rd_s_in (wr_rd_s_in),
    .addr_in    (addr_in),
    .wr_data_in (wr_data_in),
    .rd_data_out(rd_data_out),
    .ack_out    (ack_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one transfer from a negedge; cycle k=1 is the cycle right after the capture edge.
  task automatic xfer(input logic [4:0] sel, input logic wr, input logic [7:0] addr,
                      input logic [7:0] data, output logic [7:0] rd, output int ack_k,
                      output int nack, output int stray);
    sel_en_in  = sel;
    wr_rd_s_in = wr;
    addr_in    = addr;
    wr_data_in = data;
    ack_k = -1; nack = 0; stray = 0; rd = 8'h00;
    @(posedge clock);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (!ack_out && rd_data_out !== 8'h00) stray++;
      if (ack_out) begin
        nack++;
        if (ack_k < 0) begin
          ack_k = k;
          rd = rd_data_out;
        end
        sel_en_in = 5'b00000;
      end
    end
    sel_en_in = 5'b00000;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    sel_en_in = 5'b00000; wr_rd_s_in = 1'b0; addr_in = 8'h00; wr_data_in = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (ack_out !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %0b want 0", ack_out); end
    n_checks++;
    if (rd_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_rd got %h want 00", rd_data_out); end
    reset = 1'b0;
  endtask

  task automatic test_write_read;
    logic [7:0] rd; int k, n, s;
    xfer(5'b00100, 1'b1, 8'h03, 8'h5A, rd, k, n, s);
    n_checks++;
    if (k !== 3) begin n_fail++; $display("FAIL wr_latency got %0d want 3", k); end
    n_checks++;
    if (n !== 1) begin n_fail++; $display("FAIL wr_ack_count got %0d want 1", n); end
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL wr_ack_rd got %h want 00", rd); end
    xfer(5'b00100, 1'b0, 8'h03, 8'h00, rd, k, n, s);
    n_checks++;
    if (rd !== 8'h5A || k !== 3) begin n_fail++; $display("FAIL rd_03 got %h@%0d want 5a@3", rd, k); end
    n_checks++;
    if (s !== 0) begin n_fail++; $display("FAIL rd_stray got %0d want 0", s); end
  endtask

  task automatic test_id_reg;
    logic [7:0] rd; int k, n, s;
    xfer(5'b00100, 1'b0, 8'h0F, 8'h00, rd, k, n, s);
    n_checks++;
    if (rd !== 8'hA2 || n !== 1) begin n_fail++; $display("FAIL id_read got %h n=%0d want a2 n=1", rd, n); end
    xfer(5'b00100, 1'b1, 8'h0F, 8'h11, rd, k, n, s);
    n_checks++;
    if (n !== 1) begin n_fail++; $display("FAIL id_write_ack got %0d want 1", n); end
    xfer(5'b00100, 1'b0, 8'h0F, 8'h00, rd, k, n, s);
    n_checks++;
    if (rd !== 8'hA2) begin n_fail++; $display("FAIL id_after_write got %h want a2", rd); end
  endtask

  task automatic test_out_of_range;
    logic [7:0] rd; int k, n, s;
    xfer(5'b00100, 1'b0, 8'h23, 8'h00, rd, k, n, s);
    n_checks++;
    if (rd !== 8'hFF || n !== 1) begin n_fail++; $display("FAIL oor_read got %h n=%0d want ff n=1", rd, n); end
    xfer(5'b00100, 1'b1, 8'h13, 8'h77, rd, k, n, s);
    n_checks++;
    if (n !== 1) begin n_fail++; $display("FAIL oor_write_ack got %0d want 1", n); end
    xfer(5'b00100, 1'b0, 8'h03, 8'h00, rd, k, n, s);
    n_checks++;
    if (rd !== 8'h5A) begin n_fail++; $display("FAIL oor_alias got %h want 5a", rd); end
  endtask

  task automatic test_held_select;
    logic [7:0] rd; int k, n, s, acks;
    acks = 0;
    sel_en_in = 5'b00100; wr_rd_s_in = 1'b0; addr_in = 8'h03;
    @(posedge clock);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      if (ack_out) acks++;
    end
    n_checks++;
    if (acks !== 1) begin n_fail++; $display("FAIL held_sel_acks got %0d want 1", acks); end
    sel_en_in = 5'b00000;
    repeat (2) @(negedge clock);
    xfer(5'b00100, 1'b0, 8'h03, 8'h00, rd, k, n, s);
    n_checks++;
    if (k !== 3 || rd !== 8'h5A) begin n_fail++; $display("FAIL reassert got %h@%0d want 5a@3", rd, k); end
  endtask

  task automatic test_capture;
    logic [7:0] rd; int k, n, s;
    sel_en_in = 5'b00100; wr_rd_s_in = 1'b1; addr_in = 8'h06; wr_data_in = 8'h66;
    @(posedge clock);
    @(negedge clock);
    wr_rd_s_in = 1'b0; addr_in = 8'h07; wr_data_in = 8'h99;
    repeat (3) @(negedge clock);
    sel_en_in = 5'b00000;
    repeat (2) @(negedge clock);
    xfer(5'b00100, 1'b0, 8'h06, 8'h00, rd, k, n, s);
    n_checks++;
    if (rd !== 8'h66) begin n_fail++; $display("FAIL capture_06 got %h want 66", rd); end
    xfer(5'b00100, 1'b0, 8'h07, 8'h00, rd, k, n, s);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL capture_07 got %h want 00", rd); end
  endtask

  task automatic test_abort;
    logic [7:0] rd; int k, n, s, acks;
    acks = 0;
    sel_en_in = 5'b00100; wr_rd_s_in = 1'b1; addr_in = 8'h05; wr_data_in = 8'hC3;
    @(posedge clock);
    @(negedge clock);
    sel_en_in = 5'b00000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (ack_out) acks++;
    end
    n_checks++;
    if (acks !== 0) begin n_fail++; $display("FAIL abort_acks got %0d want 0", acks); end
    xfer(5'b00100, 1'b0, 8'h05, 8'h00, rd, k, n, s);
    n_checks++;
    if (rd !== 8'h00 || n !== 1) begin n_fail++; $display("FAIL abort_read got %h n=%0d want 00 n=1", rd, n); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd; int k, n, s, acks;
    acks = 0;
    sel_en_in = 5'b00100; wr_rd_s_in = 1'b1; addr_in = 8'h01; wr_data_in = 8'hEE;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    sel_en_in = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (ack_out) acks++;
    end
    n_checks++;
    if (acks !== 0) begin n_fail++; $display("FAIL reset_mid_acks got %0d want 0", acks); end
    reset = 1'b0;
    xfer(5'b00100, 1'b0, 8'h01, 8'h00, rd, k, n, s);
    n_checks++;
    if (rd !== 8'h00 || n !== 1) begin n_fail++; $display("FAIL reset_mid_01 got %h n=%0d want 00 n=1", rd, n); end
    xfer(5'b00100, 1'b0, 8'h03, 8'h00, rd, k, n, s);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_clears_03 got %h want 00", rd); end
  endtask

  task automatic test_other_select;
    logic [7:0] rd; int k, n, s;
    xfer(5'b01000, 1'b1, 8'h02, 8'h44, rd, k, n, s);
    n_checks++;
    if (n !== 0) begin n_fail++; $display("FAIL other_sel_acks got %0d want 0", n); end
    xfer(5'b11011, 1'b1, 8'h02, 8'h44, rd, k, n, s);
    n_checks++;
    if (n !== 0) begin n_fail++; $display("FAIL multi_hot_off_acks got %0d want 0", n); end
    xfer(5'b11111, 1'b1, 8'h02, 8'h3C, rd, k, n, s);
    n_checks++;
    if (n !== 1 || k !== 3) begin n_fail++; $display("FAIL multi_hot_on got n=%0d@%0d want 1@3", n, k); end
    xfer(5'b00100, 1'b0, 8'h02, 8'h00, rd, k, n, s);
    n_checks++;
    if (rd !== 8'h3C) begin n_fail++; $display("FAIL multi_hot_data got %h want 3c", rd); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_id_reg;
    test_out_of_range;
    test_held_select;
    test_capture;
    test_abort;
    test_reset_mid;
    test_other_select;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_dec_target.md
ADDR_DEC_TARGET -- requirements
Module: addr_dec_target

Interface
REQ-001 Parameter SLAVE_ID, default 0, index (0..4) of the sel_en bit this target answers to.
REQ-002 Parameter WAIT_CYCLES, default 1, number of wait cycles (0..15) inserted before ack.
REQ-003 clock  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising edge of clock.
REQ-005 sel_en_in  input  5  one-hot target select from decoder; only bit SLAVE_ID is used.
REQ-006 wr_rd_s_in  input  1  1 = write, 0 = read; valid while selected.
REQ-007 addr_in  input  8  register address; valid while selected.
REQ-008 wr_data_in  input  8  write data; valid while selected.
REQ-009 rd_data_out  output  8  read data; valid only in the ack cycle.
REQ-010 ack_out  output  1  single-cycle transfer acknowledge; feeds bit SLAVE_ID of the decoder's ack bus.

Function
REQ-011 Register file: 16 x 8 bits, indexed by addr_in[3:0]; entries 0..14 read/write.
REQ-012 Entry 15 is read-only ID = 8'hA0 | SLAVE_ID; writes to it are ignored but acked.
REQ-013 addr_in[7:4] != 0 is out of range: write ignored, read returns 8'hFF, ack still given.
REQ-014 FSM states: IDLE, WAIT, ACK, RELEASE.
REQ-015 IDLE: sel_en_in[SLAVE_ID]=1 captures wr_rd_s_in, addr_in, wr_data_in; goes to WAIT if WAIT_CYCLES>0, else ACK.
REQ-016 WAIT: 4-bit counter counts WAIT_CYCLES cycles, then goes to ACK.
REQ-017 ACK: ack_out=1 for exactly one cycle; write committed to register file in this cycle; read drives rd_data_out from captured address.
REQ-018 Latency: select sampled at edge N -> ack_out high in cycle N+1+WAIT_CYCLES.
REQ-019 ACK always goes to RELEASE; RELEASE holds until sel_en_in[SLAVE_ID]=0, then IDLE (no second transfer on a held select).
REQ-020 Captured values are used for the whole transfer; changes on inputs after capture are ignored.
REQ-021 Select dropped during WAIT: abort to IDLE, no ack, no register write.
REQ-022 rd_data_out = 8'h00 and ack_out = 0 in every cycle other than a read ACK (ack_out also 1 in write ACK, rd_data_out 0).
REQ-023 sel_en_in bits other than SLAVE_ID have no effect, including multi-hot patterns.
REQ-024 Read of an entry in the same cycle as its write is not possible (one transfer at a time).

Reset
REQ-025 reset=1 at a rising edge: state IDLE, wait counter 0, registers 0..14 = 8'h00, ack_out=0, rd_data_out=8'h00.
REQ-026 reset overrides any state, including mid-WAIT or ACK; an in-flight write is not committed.
REQ-027 First transfer is accepted at the first edge with reset=0 and select asserted.

Verification (SLAVE_ID=2, WAIT_CYCLES=2)
REQ-028 Write sel_en=5'b00100, wr_rd=1, addr=8'h03, data=8'h5A at edge N -> ack_out=1 in cycle N+3 only; later read of 8'h03 returns 8'h5A with ack.
REQ-029 Read addr=8'h0F -> rd_data_out=8'hA2 with ack; write 8'h11 to 8'h0F then read -> still 8'hA2.
REQ-030 Read addr=8'h23 -> rd_data_out=8'hFF with ack; write 8'h77 to 8'h13 -> entry 3 unchanged.
REQ-031 Select held high 6 cycles after ack -> exactly one ack; deassert then reassert -> new transfer acked.
REQ-032 Select dropped one cycle after capture (write 8'hC3 to 8'h05) -> no ack; read 8'h05 returns 8'h00.
REQ-033 reset asserted in WAIT of write 8'hEE to 8'h01 -> ack_out=0, read 8'h01 after reset returns 8'h00; sel_en=5'b01000 alone -> never acked.
